bus_arbiter: RTL
================

# bus_arbiter

Shared-bus arbiter and sequencer between the core's memory requesters (LSU, instruction fetch, optional DMA) and the single system bus slave port. It grants the bus to one master at a time using round-robin priority and routes that master's address, data, strobe and byte-select signals to the slave. It returns read data and a one-cycle acknowledge to the owner, and aborts stalled transfers through a watchdog. Each master-side port connects directly to an LSU-style `o_BUS_*` / `o_BUS_REQ` / `i_BUS_GNT` interface.

## Interface
Parameters:
- `N_MASTERS`, default 2: number of requesters; legal range 2..8. Master 0 is the LSU by convention.
- `TIMEOUT`, default 255: maximum number of BUSY cycles without slave ack before the transfer is aborted. A value of 0 disables the watchdog.

Ports:
- `i_CLK`  in  1: single clock; all logic is rising-edge.
- `i_RSTn`  in  1: reset, synchronous, active-low.
- `i_M_REQ`  in  N_MASTERS: per-master request.
- `i_M_WE`, `i_M_RE`  in  N_MASTERS each: per-master write/read strobe.
- `i_M_HB`  in  2*N_MASTERS: per-master size (byte/half/word), packed with master k at `[2k+1:2k]`.
- `i_M_ADDR`, `i_M_WDATA`  in  32*N_MASTERS each: packed with master k at `[32k+31:32k]`.
- `o_M_GNT`  out  N_MASTERS: one-hot grant; all zero when idle.
- `o_M_ACK`  out  N_MASTERS: one-cycle completion pulse to the owner.
- `o_M_ERR`  out  1: qualifies `o_M_ACK`; 1 means the transfer timed out.
- `o_M_RDATA`  out  32: registered read data, broadcast to all masters.
- `o_S_ADDR`, `o_S_WDATA`  out  32: to slave.
- `o_S_WE`, `o_S_RE`  out  1: to slave.
- `o_S_HB`  out  2: to slave.
- `i_S_RDATA`  in  32: slave read data.
- `i_S_ACK`  in  1: slave completion, valid in any BUSY cycle.

## Operation
- States:
  - IDLE: no owner.
  - BUSY: owner's transfer is on the slave port.
  - DONE: ack cycle.
- IDLE:
  - If any `i_M_REQ` bit is set, select the first requester at or after `rr_ptr`, searching upward modulo N_MASTERS.
  - Register the selection in `owner`, clear `wd_cnt`, and go to BUSY.
  - Otherwise remain in IDLE.
- BUSY:
  - `o_M_GNT` is one-hot on `owner`.
  - Slave outputs combinationally mux the owner's inputs.
  - `o_S_WE = i_M_WE[owner]`.
  - `o_S_RE = i_M_RE[owner] & ~i_M_WE[owner]`, so write wins if both strobes are set.
  - When `i_S_ACK` = 1: capture `i_S_RDATA` into `o_M_RDATA` (reads only; writes leave it unchanged), set ERR = 0, go to DONE.
  - Else if `i_M_REQ[owner]` = 0: the master aborted. Go to IDLE with no ack; `rr_ptr` is unchanged.
  - Else if TIMEOUT != 0 and `wd_cnt` == TIMEOUT-1: set ERR = 1 and go to DONE.
  - Otherwise increment `wd_cnt`.
- DONE:
  - `o_M_ACK[owner]` = 1 for exactly this cycle; `o_M_ERR` is valid during this cycle.
  - `o_M_GNT` = 0 and all slave strobes are 0.
  - Set `rr_ptr` to (`owner` + 1) mod N_MASTERS, then go to IDLE.
- Outside BUSY, `o_S_WE`, `o_S_RE` and `o_S_HB` are 0. `o_S_ADDR` and `o_S_WDATA` are 0 when idle, so there are no spurious strobes.
- Masters must hold ADDR, WDATA, WE, RE and HB stable from REQ assertion until ACK. The arbiter does not re-sample them.
- `wd_cnt` is `$clog2(TIMEOUT+1)` bits wide. A TIMEOUT of 1 aborts on the first BUSY cycle that has no ack.

## Timing
- Reset (`i_RSTn` low at a rising edge):
  - State = IDLE; `owner` = 0; `rr_ptr` = 0; `wd_cnt` = 0.
  - `o_M_GNT` = 0, `o_M_ACK` = 0, `o_M_ERR` = 0, `o_M_RDATA` = 0.
  - All `o_S_*` = 0.
  - Reset mid-transfer drops the transfer silently; no ack is issued.
- Latency: REQ sampled high in IDLE at edge 0 → GNT and slave strobes from edge 1. An `i_S_ACK` seen in the BUSY cycle ending at edge n → `o_M_ACK` high from edge n to n+1.
- A zero-wait slave (ack in the first BUSY cycle) gives 3 cycles per transfer: IDLE, BUSY, DONE.
- Back-to-back: the minimum is one IDLE cycle between grants. A master holding REQ through its ack is re-arbitrated in that IDLE cycle.
- Simultaneous events:
  - `i_S_ACK` and watchdog expiry in the same cycle: ack wins, ERR = 0.
  - `i_S_ACK` and owner REQ drop in the same cycle: ack wins; DONE is entered.
  - REQ changes from non-owners during BUSY are ignored.
- Fairness: with all N masters continuously requesting, each is granted exactly once per N transfers.

## Test plan
- Single master 0 read; slave acks in the 1st BUSY cycle with 0xDEADBEEF:
  - `o_M_GNT` = 01 for 1 cycle.
  - `o_M_ACK[0]` pulses 2 cycles after REQ; `o_M_RDATA` = 0xDEADBEEF; `o_M_ERR` = 0.
- N=2, both masters request continuously, zero-wait slave → grants alternate 0,1,0,1; each ACK is 3 cycles apart.
- Master 1 write with WE=1, RE=1, ADDR=0x1000_0004, HB=2, WDATA=0x12345678:
  - Slave sees WE=1, RE=0 and exactly those ADDR/HB/WDATA values.
  - `o_M_RDATA` keeps its previous value.
- TIMEOUT=4, slave never acks → `o_M_ACK[owner]` and `o_M_ERR` both high in the cycle after the 4th BUSY cycle; the next grant goes to the other master.
- Owner drops REQ in its 2nd BUSY cycle → next cycle is IDLE with GNT = 0, no ACK, and `rr_ptr` unchanged.
- `i_RSTn` low during BUSY → the next cycle has all outputs 0 and no ACK; `rr_ptr` = 0, so master 0 wins the following contention.

Source files
------------

// File: rtl/bus_arbiter.sv
// Round-robin shared-bus arbiter: grants one master at a time, muxes its
// transfer onto the slave port, returns ack/rdata and aborts stalled transfers.
module bus_arbiter #(
    parameter int N_MASTERS = 2,
    parameter int TIMEOUT   = 255
) (
    input  logic                   i_CLK,
    input  logic                   i_RSTn,
    input  logic [N_MASTERS-1:0]   i_M_REQ,
    input  logic [N_MASTERS-1:0]   i_M_WE,
    input  logic [N_MASTERS-1:0]   i_M_RE,
    input  logic [2*N_MASTERS-1:0] i_M_HB,
    input  logic [32*N_MASTERS-1:0] i_M_ADDR,
    input  logic [32*N_MASTERS-1:0] i_M_WDATA,
    output logic [N_MASTERS-1:0]   o_M_GNT,
    output logic [N_MASTERS-1:0]   o_M_ACK,
    output logic                   o_M_ERR,
    output logic [31:0]            o_M_RDATA,
    output logic [31:0]            o_S_ADDR,
    output logic [31:0]            o_S_WDATA,
    output logic                   o_S_WE,
    output logic                   o_S_RE,
    output logic [1:0]             o_S_HB,
    input  logic [31:0]            i_S_RDATA,
    input  logic                   i_S_ACK
);

    localparam int OW = $clog2(N_MASTERS);
    // A disabled watchdog still needs a 1-bit counter to stay legal.
    localparam int WW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam int WD_LAST_I = (TIMEOUT > 0) ? TIMEOUT - 1 : 0;
    localparam logic [WW-1:0] WD_LAST = WD_LAST_I[WW-1:0];
    localparam logic [OW:0] N_EXT = (OW + 1)'(N_MASTERS);

    typedef enum logic [1:0] {
        S_IDLE,
        S_BUSY,
        S_DONE
    } state_t;

    state_t        r_state;
    state_t        w_next;
    logic [OW-1:0] r_owner;
    logic [OW-1:0] r_rr_ptr;
    logic [WW-1:0] r_wd_cnt;
    logic          r_err;
    logic [31:0]   r_rdata;

    logic [OW-1:0] w_pick;
    logic          w_found;
    logic [OW:0]   w_sum;
    logic [OW:0]   w_inc;
    logic [OW-1:0] w_owner_inc;
    logic          w_any_req;
    logic          w_own_req;
    logic          w_own_we;
    logic          w_own_re;
    logic          w_is_read;
    logic          w_wd_hit;

    logic [31:0]   w_addr  [N_MASTERS];
    logic [31:0]   w_wdata [N_MASTERS];
    logic [1:0]    w_hb    [N_MASTERS];

    // Split the packed per-master buses into indexable arrays.
    for (genvar g = 0; g < N_MASTERS; g++) begin : g_unpack
        assign w_addr[g]  = i_M_ADDR[32*g +: 32];
        assign w_wdata[g] = i_M_WDATA[32*g +: 32];
        assign w_hb[g]    = i_M_HB[2*g +: 2];
    end

    assign w_any_req = |i_M_REQ;
    assign w_own_req = i_M_REQ[r_owner];
    assign w_own_we  = i_M_WE[r_owner];
    assign w_own_re  = i_M_RE[r_owner];
    // Write wins when a master raises both strobes.
    assign w_is_read = w_own_re & ~w_own_we;
    assign w_wd_hit  = (TIMEOUT != 0) && (r_wd_cnt == WD_LAST);

    // Search upward from the round-robin pointer for the first requester.
    always_comb begin
        w_pick  = r_rr_ptr;
        w_found = 1'b0;
        w_sum   = '0;
        for (int k = 0; k < N_MASTERS; k++) begin
            w_sum = {1'b0, r_rr_ptr} + (OW + 1)'(k);
            if (w_sum >= N_EXT) begin
                w_sum = w_sum - N_EXT;
            end
            if (!w_found && i_M_REQ[w_sum[OW-1:0]]) begin
                w_pick  = w_sum[OW-1:0];
                w_found = 1'b1;
            end
        end
    end

    // Pointer value that follows the current owner, wrapping at N_MASTERS.
    always_comb begin
        w_inc = {1'b0, r_owner} + (OW + 1)'(1);
        if (w_inc >= N_EXT) begin
            w_inc = '0;
        end
        w_owner_inc = w_inc[OW-1:0];
    end

    // State register.
    always_ff @(posedge i_CLK) begin
        if (!i_RSTn) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state decode and all bus-facing outputs.
    always_comb begin
        w_next    = r_state;
        o_M_GNT   = '0;
        o_M_ACK   = '0;
        o_M_ERR   = 1'b0;
        o_S_ADDR  = '0;
        o_S_WDATA = '0;
        o_S_WE    = 1'b0;
        o_S_RE    = 1'b0;
        o_S_HB    = '0;
        unique case (r_state)
            S_IDLE: begin
                if (w_any_req) begin
                    w_next = S_BUSY;
                end
            end
            S_BUSY: begin
                o_M_GNT   = N_MASTERS'(1) << r_owner;
                o_S_ADDR  = w_addr[r_owner];
                o_S_WDATA = w_wdata[r_owner];
                o_S_HB    = w_hb[r_owner];
                o_S_WE    = w_own_we;
                o_S_RE    = w_is_read;
                if (i_S_ACK) begin
                    w_next = S_DONE;
                end else if (!w_own_req) begin
                    w_next = S_IDLE;
                end else if (w_wd_hit) begin
                    w_next = S_DONE;
                end
            end
            S_DONE: begin
                o_M_ACK = N_MASTERS'(1) << r_owner;
                o_M_ERR = r_err;
                w_next  = S_IDLE;
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    // Owner, pointer, watchdog, error flag and read-data capture.
    always_ff @(posedge i_CLK) begin
        if (!i_RSTn) begin
            r_owner  <= '0;
            r_rr_ptr <= '0;
            r_wd_cnt <= '0;
            r_err    <= 1'b0;
            r_rdata  <= '0;
        end else begin
            unique case (r_state)
                S_IDLE: begin
                    if (w_any_req) begin
                        r_owner  <= w_pick;
                        r_wd_cnt <= '0;
                    end
                end
                S_BUSY: begin
                    if (i_S_ACK) begin
                        if (w_is_read) begin
                            r_rdata <= i_S_RDATA;
                        end
                        r_err <= 1'b0;
                    end else if (!w_own_req) begin
                        r_err <= r_err;
                    end else if (w_wd_hit) begin
                        r_err <= 1'b1;
                    end else begin
                        r_wd_cnt <= r_wd_cnt + WW'(1);
                    end
                end
                S_DONE: begin
                    r_rr_ptr <= w_owner_inc;
                end
                default: begin
                    r_err <= r_err;
                end
            endcase
        end
    end

    assign o_M_RDATA = r_rdata;

endmodule
